// File: rtl/ahb_bm_dma_phy_pkg.sv
// Shared constants and types for the DMA/PHY output-port arbiter.
// Build option: AHB_BM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package ahb_bm_dma_phy_pkg;

   localparam int unsigned NumPortsDefault = 3;
   // Encoded port indices are two bits wide, so at most four ports per output.
   localparam int unsigned PortIdxW = 2;

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      StNoPort = 2'b00,
      StGrant  = 2'b01,
      StHold   = 2'b10
   } arb_state_e;

   // SEQ and BUSY both mean a burst is still in flight.
   function automatic logic is_burst_beat(logic [1:0] htrans);
      return (htrans == HtransSeq) || (htrans == HtransBusy);
   endfunction

endpackage

// File: rtl/ahb_busmatrix_dma_phy_out_arb_if.sv
// Request/ownership bundle between the input stages and one output-port arbiter.
// master drives the requests and HREADY; slave is the arbiter side.
interface ahb_busmatrix_dma_phy_out_arb_if
   import ahb_bm_dma_phy_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NumPortsDefault
);

   logic [NUM_PORTS-1:0]   req_in;
   logic [2*NUM_PORTS-1:0] htrans_in;
   logic [NUM_PORTS-1:0]   hmastlock_in;
   logic                   hready_m;
   logic [NUM_PORTS-1:0]   grant;
   logic [PortIdxW-1:0]    addr_in_port;
   logic [PortIdxW-1:0]    data_in_port;
   logic                   no_port;

   modport master (
      output req_in,
      output htrans_in,
      output hmastlock_in,
      output hready_m,
      input  grant,
      input  addr_in_port,
      input  data_in_port,
      input  no_port
   );

   modport slave (
      input  req_in,
      input  htrans_in,
      input  hmastlock_in,
      input  hready_m,
      output grant,
      output addr_in_port,
      output data_in_port,
      output no_port
   );

endinterface

// File: rtl/ahb_busmatrix_dma_phy_arb_sel.sv
// Combinational rotating-priority encoder: the first requester at or after base_i wins.
// A constant base_i of zero gives fixed priority with port 0 highest.
module ahb_busmatrix_dma_phy_arb_sel
   import ahb_bm_dma_phy_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NumPortsDefault
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [PortIdxW-1:0]  base_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PortIdxW-1:0]  gnt_idx_o,
   output logic                 valid_o
);

   logic                found;
   logic [PortIdxW-1:0] pidx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      pidx      = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         pidx = PortIdxW'((32'(base_i) + k) % NUM_PORTS);
         if (!found && req_i[pidx]) begin
            found       = 1'b1;
            gnt_o[pidx] = 1'b1;
            gnt_idx_o   = pidx;
         end
      end
   end

   assign valid_o = found;

endmodule

// File: rtl/ahb_busmatrix_dma_phy_out_arb.sv
// Output-port arbiter of the DMA/PHY bus matrix: picks the address-phase owner, holds it
// across bursts and locked sequences. Build option: AHB_BM_ARB_ROUND_ROBIN_EN.
module ahb_busmatrix_dma_phy_out_arb
   import ahb_bm_dma_phy_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NumPortsDefault
) (
   input logic HCLK,
   input logic HRESETn,
   ahb_busmatrix_dma_phy_out_arb_if.slave bus
);

   arb_state_e           state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [PortIdxW-1:0]  addr_q, addr_d;
   logic [PortIdxW-1:0]  data_q, data_d;
   logic [PortIdxW-1:0]  base;

   logic [NUM_PORTS-1:0] sel_gnt;
   logic [PortIdxW-1:0]  sel_idx;
   logic                 sel_valid;

   logic [1:0] owner_trans;
   logic       owner_lock;
   logic       keep_from_grant;
   logic       keep_in_hold;
   logic       arb_now;

   // addr_q always names the current owner whenever the state is not StNoPort.
   assign owner_trans = bus.htrans_in[{addr_q, 1'b0} +: 2];
   assign owner_lock  = bus.hmastlock_in[addr_q];

   assign keep_from_grant = is_burst_beat(owner_trans) ||
                            ((owner_trans == HtransNonseq) && owner_lock);
   assign keep_in_hold    = is_burst_beat(owner_trans) || owner_lock;

`ifdef AHB_BM_ARB_ROUND_ROBIN_EN
   logic [PortIdxW-1:0] last_q, last_d;

   assign base = (last_q == PortIdxW'(NUM_PORTS - 1)) ? '0 : last_q + 1'b1;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_q <= PortIdxW'(NUM_PORTS - 1);
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign base = '0;
`endif

   ahb_busmatrix_dma_phy_arb_sel #(
      .NUM_PORTS (NUM_PORTS)
   ) u_arb_sel (
      .req_i     (bus.req_in),
      .base_i    (base),
      .gnt_o     (sel_gnt),
      .gnt_idx_o (sel_idx),
      .valid_o   (sel_valid)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      data_d  = data_q;
      arb_now = 1'b0;
`ifdef AHB_BM_ARB_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      // Everything is frozen while the current transfer is stalled.
      if (bus.hready_m) begin
         data_d = addr_q;
         case (state_q)
            StNoPort: arb_now = 1'b1;
            StGrant: begin
               if (keep_from_grant) begin
                  state_d = StHold;
               end else begin
                  arb_now = 1'b1;
               end
            end
            StHold:   arb_now = !keep_in_hold;
            default:  arb_now = 1'b1;
         endcase

         if (arb_now) begin
            if (sel_valid) begin
               state_d = StGrant;
               grant_d = sel_gnt;
               addr_d  = sel_idx;
`ifdef AHB_BM_ARB_ROUND_ROBIN_EN
               last_d  = sel_idx;
`endif
            end else begin
               // addr_in_port keeps its last value while the default slave is selected.
               state_d = StNoPort;
               grant_d = '0;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= StNoPort;
         grant_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.addr_in_port = addr_q;
   assign bus.data_in_port = data_q;
   assign bus.no_port      = (state_q == StNoPort);

endmodule

// File: tb/tb_ahb_busmatrix_dma_phy_out_arb.sv
// Bench for the output-port arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level ownership model.
module tb_ahb_busmatrix_dma_phy_out_arb;

   localparam int unsigned N = 3;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 1'b0;

   ahb_busmatrix_dma_phy_out_arb_if #(.NUM_PORTS(N)) bus ();

   ahb_busmatrix_dma_phy_out_arb #(
      .NUM_PORTS (N)
   ) dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: who owns the output, whether that owner is pinned, and the two phase indices.
   typedef struct {
      bit owned;
      bit holding;
      int addr;
      int data;
      int last;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.owned   = 0;
      r.holding = 0;
      r.addr    = 0;
      r.data    = 0;
      r.last    = N - 1;
      return r;
   endfunction

   function automatic int pick(logic [N-1:0] req, int base);
      for (int k = 0; k < N; k++) begin
         int p;
         p = (base + k) % N;
         if (req[p]) return p;
      end
      return -1;
   endfunction

   function automatic mdl_t model_next(mdl_t s, logic [N-1:0] req, logic [2*N-1:0] tr,
                                       logic [N-1:0] lk, logic rdy);
      mdl_t n;
      int   t;
      bit   burst;
      bit   arb;
      int   w;
      int   base;
      n = s;
      if (!rdy) return s;
      n.data = s.addr;
      t      = int'(tr[2*s.addr +: 2]);
      burst  = (t == 3) || (t == 1);
      if (!s.owned)        arb = 1;
      else if (!s.holding) arb = !(burst || (t == 2 && lk[s.addr]));
      else                 arb = !(burst || lk[s.addr]);
      if (arb) begin
`ifdef AHB_BM_ARB_ROUND_ROBIN_EN
         base = (s.last + 1) % N;
`else
         base = 0;
`endif
         w         = pick(req, base);
         n.holding = 0;
         if (w < 0) begin
            n.owned = 0;
         end else begin
            n.owned = 1;
            n.addr  = w;
            n.last  = w;
         end
      end else begin
         n.holding = 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= mdl_reset();
      else m <= model_next(m, bus.req_in, bus.htrans_in, bus.hmastlock_in, bus.hready_m);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_grant", 32'(bus.grant), m.owned ? (32'd1 << m.addr) : 32'd0);
         chk("cmp_no_port", 32'(bus.no_port), m.owned ? 32'd0 : 32'd1);
         chk("cmp_addr", 32'(bus.addr_in_port), 32'(m.addr));
         chk("cmp_data", 32'(bus.data_in_port), 32'(m.data));
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic [2*N-1:0] t, input logic [N-1:0] l,
                        input logic rdy);
      bus.req_in       = r;
      bus.htrans_in    = t;
      bus.hmastlock_in = l;
      bus.hready_m     = rdy;
   endtask

   task automatic chk_outs(input string name, input int g, input int np, input int a,
                           input int d);
      chk({name, "_grant"}, 32'(bus.grant), 32'(g));
      chk({name, "_no_port"}, 32'(bus.no_port), 32'(np));
      chk({name, "_addr"}, 32'(bus.addr_in_port), 32'(a));
      chk({name, "_data"}, 32'(bus.data_in_port), 32'(d));
   endtask

`ifdef AHB_BM_ARB_ROUND_ROBIN_EN
   localparam bit Rr = 1'b1;
`else
   localparam bit Rr = 1'b0;
`endif

   int exp_rr3 [3];
   int exp_g;
   int exp_a;

   initial begin
      rst_n = 1'b0;
      drive('0, '0, '0, 1'b1);
      repeat (2) @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      chk_outs("reset", 0, 1, 0, 0);
      rst_n = 1'b1;

      // Single request from port 0 after reset.
      drive(3'b001, 6'b00_00_10, '0, 1'b1);
      @(negedge clk);
      chk("first_grant", 32'(bus.grant), 32'd1);
      chk("first_addr", 32'(bus.addr_in_port), 32'd0);
      chk("first_no_port", 32'(bus.no_port), 32'd0);
      drive('0, '0, '0, 1'b1);
      @(negedge clk);
      chk("first_data", 32'(bus.data_in_port), 32'd0);
      chk("idle_no_port", 32'(bus.no_port), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Three single NONSEQ transfers with all ports requesting.
      exp_rr3 = Rr ? '{1, 2, 4} : '{1, 1, 1};
      drive(3'b111, 6'b10_10_10, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("single_grant", 32'(bus.grant), 32'(exp_rr3[i]));
      end

      // Port 1 INCR4 burst: owned for four beats, then released.
      drive(3'b010, 6'b00_10_00, '0, 1'b1);
      @(negedge clk);
      chk("burst_beat1", 32'(bus.grant), 32'd2);
      drive(3'b111, 6'b10_11_10, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("burst_beat", 32'(bus.grant), 32'd2);
      end
      drive(3'b111, 6'b10_00_10, '0, 1'b1);
      @(negedge clk);
      chk("burst_after", 32'(bus.grant), Rr ? 32'd4 : 32'd1);

      // Port 0 locked sequence with IDLE between locked transfers.
      drive(3'b001, 6'b00_00_10, 3'b001, 1'b1);
      @(negedge clk);
      chk("lock_grant", 32'(bus.grant), 32'd1);
      @(negedge clk);
      chk("lock_hold0", 32'(bus.grant), 32'd1);
      drive(3'b111, 6'b10_10_00, 3'b001, 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("lock_idle", 32'(bus.grant), 32'd1);
      end
      drive(3'b111, 6'b10_10_10, 3'b001, 1'b1);
      @(negedge clk);
      chk("lock_nonseq", 32'(bus.grant), 32'd1);
      drive(3'b111, 6'b10_10_00, 3'b000, 1'b1);
      @(negedge clk);
      exp_g = Rr ? 2 : 1;
      exp_a = Rr ? 1 : 0;
      chk("unlock_grant", 32'(bus.grant), 32'(exp_g));
      chk("unlock_addr", 32'(bus.addr_in_port), 32'(exp_a));

      // Stall: outputs must not move while requests churn.
      for (int i = 0; i < 5; i++) begin
         drive(3'($urandom), 6'($urandom), 3'($urandom), 1'b0);
         @(negedge clk);
         chk_outs("stall", exp_g, 0, exp_a, 0);
      end

      // Reset in the middle of a port 2 burst.
      drive(3'b100, 6'b10_00_00, '0, 1'b1);
      @(negedge clk);
      chk("pre_rst_grant", 32'(bus.grant), 32'd4);
      drive(3'b100, 6'b11_00_00, '0, 1'b1);
      @(negedge clk);
      chk("seq_grant", 32'(bus.grant), 32'd4);
      #2 rst_n = 1'b0;
      #1 chk_outs("async_rst", 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive('0, 6'b11_00_00, '0, 1'b1);
      @(negedge clk);
      chk("post_rst_no_port", 32'(bus.no_port), 32'd1);
      chk("post_rst_grant", 32'(bus.grant), 32'd0);

      // Randomized traffic; the compare process checks every cycle.
      for (int i = 0; i < 2000; i++) begin
         logic [N-1:0] lk;
         lk = '0;
         for (int p = 0; p < N; p++) lk[p] = ($urandom_range(0, 7) == 0);
         drive(3'($urandom), 6'($urandom), lk, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_busmatrix_dma_phy_out_arb.md
AHB_BUSMATRIX_DMA_PHY_OUT_ARB -- requirements
Module: ahb_busmatrix_dma_phy_out_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of input ports competing for one output (slave) port.
REQ-002 SHALL have port HCLK  input  1  AHB system clock; the block uses this single clock.
REQ-003 SHALL have port HRESETn  input  1  AHB reset; asynchronous assert, active-low.
REQ-004 SHALL have port req_in  input  NUM_PORTS  per-port request, address phase pending for this output.
REQ-005 SHALL have port htrans_in  input  2*NUM_PORTS  per-port HTRANS, packed with port 0 in bits [1:0].
REQ-006 SHALL have port hmastlock_in  input  NUM_PORTS  per-port HMASTLOCK.
REQ-007 SHALL have port hready_m  input  1  HREADY of the transfer currently on this output.
REQ-008 SHALL have port grant  output  NUM_PORTS  one-hot address-phase owner; all-zero when no owner.
REQ-009 SHALL have port addr_in_port  output  2  encoded address-phase owner.
REQ-010 SHALL have port data_in_port  output  2  encoded data-phase owner.
REQ-011 SHALL have port no_port  output  1  high when no port owns the address phase, which routes the transfer to the default slave.

Function
REQ-012 SHALL implement an FSM with states NOPORT, GRANT and HOLD.
REQ-013 SHALL freeze all state and outputs while hready_m=0.
REQ-014 SHALL define an arbitration point as hready_m=1 in NOPORT or GRANT.
REQ-015 SHALL, at an arbitration point, select the winner among req_in, register it and update the outputs on the next HCLK edge; latency is one cycle.
REQ-016 SHALL enter NOPORT with no_port=1 and grant=0 when no req_in is set at an arbitration point.
REQ-017 SHALL, from GRANT with hready_m=1, go to HOLD if the owner's HTRANS is NONSEQ and the owner's hmastlock_in=1, or if the owner's HTRANS is SEQ or BUSY.
REQ-018 SHALL, in HOLD, keep the owner while its HTRANS is SEQ or BUSY or its hmastlock_in=1, and otherwise return to arbitration on the next hready_m=1.
REQ-019 SHALL, when the owner is the only requester and no HOLD condition applies, re-grant the same owner.
REQ-020 SHALL ignore changes in req_in from non-owners while in HOLD.
REQ-021 SHALL load data_in_port from addr_in_port on every HCLK edge with hready_m=1, otherwise hold it.
REQ-022 SHALL keep addr_in_port at its last value in NOPORT.
REQ-023 SHALL, when req_in=0 for the owner in HOLD with SEQ or BUSY still signalled, keep HOLD; the protocol violation is not policed.

Reset
REQ-024 SHALL, on HRESETn=0 and immediately, set the state to NOPORT, no_port=1, grant=0, addr_in_port=0, data_in_port=0 and last_grant=NUM_PORTS-1.
REQ-025 SHALL, on reset asserted mid-burst or mid-lock, abandon the burst or lock with no residual ownership after release.

Configuration
REQ-026 SHALL use the macro AHB_BM_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-027 SHALL, with AHB_BM_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin, with priority starting at last_grant+1 modulo NUM_PORTS, and update last_grant on every new grant.
REQ-028 SHALL, with AHB_BM_ARB_ROUND_ROBIN_EN undefined, arbitrate by fixed priority with port 0 highest, and SHALL then synthesise no last_grant register.

Structure
REQ-029 SHALL place NUM_PORTS default, the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) and the FSM state encodings in the shared package ahb_bm_dma_phy_pkg.
REQ-030 SHALL place the combinational rotating-priority encoder in the sub-module ahb_busmatrix_dma_phy_arb_sel, with inputs req and base pointer and outputs one-hot winner and encoded winner.

Verification
REQ-031 SHALL cover this case: after reset, req_in=001 with hready_m=1 -> next cycle grant=001, addr_in_port=0, no_port=0; one cycle later data_in_port=0.
REQ-032 SHALL cover this case: under round-robin, req_in=111 held for 3 single NONSEQ transfers -> grants 0, 1, 2 in order.
REQ-033 SHALL cover this case: port 1 runs a 4-beat INCR4 (NONSEQ then SEQ x3) with req_in=111 -> grant stays 010 for 4 beats, then moves to port 2.
REQ-034 SHALL cover this case: port 0 sets hmastlock_in=1 with IDLE between locked transfers -> ownership is held until hmastlock_in=0 at hready_m=1.
REQ-035 SHALL cover this case: hready_m=0 for 5 cycles while req_in changes -> grant, addr_in_port and data_in_port are unchanged.
REQ-036 SHALL cover this case: HRESETn pulsed low mid-SEQ -> outputs take reset values asynchronously and no_port=1.
